// File: rtl/muldiv4_pkg.sv
// Shared encodings and default width for the iterative multiply/divide unit.
package muldiv4_pkg;

    localparam int MULDIV_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv4_addsub.sv
// W-bit adder/subtractor; cout_o is the carry out, and for subtraction it is 1 when x_i >= y_i.
module muldiv4_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    logic [W-1:0] y_eff;
    logic [W:0]   full;

    assign y_eff = sub_i ? ~y_i : y_i;
    assign full  = {1'b0, x_i} + {1'b0, y_eff} + {{W{1'b0}}, sub_i};
    assign {cout_o, sum_o} = full;

endmodule

// File: rtl/muldiv4_seq_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one step per clock.
// Defining MULDIV4_SIGNED_EN adds the signed_op input for two's-complement operands.
module muldiv4_seq_unit
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
`ifdef MULDIV4_SIGNED_EN
    input  logic               signed_op,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               op_q;
    logic [WIDTH-1:0]   sr_q, y_q, rem_q;
    logic [2*WIDTH-1:0] acc_q, result_q;
    logic               busy_q, done_q, dbz_q;
`ifdef MULDIV4_SIGNED_EN
    logic               sgn_q, negp_q, negr_q;
    logic [WIDTH-1:0]   quo_s, rem_s;
`endif

    logic [WIDTH:0]     as_x, as_y, as_sum, mul_hi;
    logic               as_cout;
    logic [2*WIDTH-1:0] acc_d, res_d;
    logic [WIDTH-1:0]   rem_d, sr_d, lat_a, lat_b;
    logic               dbz_d;

    // Signed operands enter the unsigned core as magnitudes; signs are reapplied at the result load.
    always_comb begin
        lat_a = a;
        lat_b = b;
`ifdef MULDIV4_SIGNED_EN
        if (signed_op && a[WIDTH-1]) lat_a = -a;
        if (signed_op && b[WIDTH-1]) lat_b = -b;
`endif
    end

    // Multiply adds the multiplicand into the upper half; divide trial-subtracts from the shifted remainder.
    assign as_y = {1'b0, y_q};
    assign as_x = (op_q == OP_MUL) ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} : {rem_q, sr_q[WIDTH-1]};

    muldiv4_addsub #(.W(WIDTH + 1)) u_addsub (
        .x_i    (as_x),
        .y_i    (as_y),
        .sub_i  (op_q),
        .sum_o  (as_sum),
        .cout_o (as_cout)
    );

    always_comb begin
        mul_hi = acc_q[0] ? as_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_d  = acc_q;
        rem_d  = rem_q;
        sr_d   = sr_q;
        if (op_q == OP_MUL) begin
            acc_d = {mul_hi, acc_q[WIDTH-1:1]};
        end else begin
            rem_d = as_cout ? as_sum[WIDTH-1:0] : as_x[WIDTH-1:0];
            sr_d  = {sr_q[WIDTH-2:0], as_cout};
        end
    end

    always_comb begin
        dbz_d = (op_q == OP_DIV) && (y_q == '0);
        res_d = (op_q == OP_MUL) ? acc_d : {rem_d, sr_d};
`ifdef MULDIV4_SIGNED_EN
        quo_s = sr_d;
        rem_s = rem_d;
        if (sgn_q) begin
            if (op_q == OP_MUL) begin
                if (negp_q) res_d = -acc_d;
            end else begin
                if (dbz_d)       quo_s = '1;
                else if (negp_q) quo_s = -sr_d;
                if (negr_q)      rem_s = -rem_d;
                res_d = {rem_s, quo_s};
            end
        end
`endif
    end

    // The multiplier sits in the low half of the accumulator and is consumed as the product shifts in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            sr_q     <= '0;
            y_q      <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef MULDIV4_SIGNED_EN
            sgn_q    <= 1'b0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        op_q    <= op;
                        sr_q    <= lat_a;
                        y_q     <= (op == OP_MUL) ? lat_a : lat_b;
                        rem_q   <= '0;
                        acc_q   <= {{WIDTH{1'b0}}, lat_b};
`ifdef MULDIV4_SIGNED_EN
                        sgn_q   <= signed_op;
                        negp_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negr_q  <= signed_op & a[WIDTH-1];
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= res_d;
                        dbz_q    <= dbz_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv4_seq_unit.sv
// Directed scoreboard bench for muldiv4_seq_unit; signed cases build only with MULDIV4_SIGNED_EN.
module tb_muldiv4_seq_unit;
    import muldiv4_pkg::*;

    localparam int W  = 4;
    localparam int W2 = 2 * W;

    logic          clock = 1'b0;
    logic          reset, start, op;
    logic [W-1:0]  a, b;
    logic          busy, done, divByZero;
    logic [W2-1:0] result;
`ifdef MULDIV4_SIGNED_EN
    logic          signedOp;
`endif

    typedef struct {
        logic [W2-1:0] res;
        logic          dbz;
        string         tag;
    } expect_t;

    expect_t sbQ[$];
    int      nVectors = 0;
    int      nMiss    = 0;

    always #5 clock = ~clock;

    muldiv4_seq_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
`ifdef MULDIV4_SIGNED_EN
        .signed_op   (signedOp),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (divByZero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: {div_by_zero, result}
    function automatic logic [W2:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sg);
        int sx, sy, q, r;
        logic [W-1:0] qb, rb;
        sx = sg ? int'($signed(x)) : int'(x);
        sy = sg ? int'($signed(y)) : int'(y);
        if (o == OP_MUL) return {1'b0, W2'(sx * sy)};
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        q  = sx / sy;
        r  = sx % sy;
        qb = W'(q);
        rb = W'(r);
        return {1'b0, rb, qb};
    endfunction

    task automatic applyStimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sg, input string tag);
        expect_t     e;
        logic [W2:0] m;
        m     = model(o, x, y, sg);
        e.res = m[W2-1:0];
        e.dbz = m[W2];
        e.tag = tag;
        sbQ.push_back(e);
        op    = o;
        a     = x;
        b     = y;
`ifdef MULDIV4_SIGNED_EN
        signedOp = sg;
`endif
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!done && lat < 20);
    endtask

    task automatic checkOutput(input int expLat);
        int      lat;
        expect_t e;
        e = sbQ.pop_front();
        waitDone(lat);
        check({e.tag, "_done"}, done, 1);
        check({e.tag, "_latency"}, lat, expLat);
        check({e.tag, "_result"}, result, e.res);
        check({e.tag, "_dbz"}, divByZero, e.dbz);
        @(posedge clock);
        #1;
        check({e.tag, "_pulse"}, done, 0);
        check({e.tag, "_hold"}, result, e.res);
    endtask

    initial begin
        int doneCount;
        reset = 1'b1;
        start = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
`ifdef MULDIV4_SIGNED_EN
        signedOp = 1'b0;
`endif
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_dbz", divByZero, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        applyStimulus(OP_MUL, 4'd15, 4'd15, 1'b0, "mul_15x15");  checkOutput(4);
        applyStimulus(OP_DIV, 4'd13, 4'd4,  1'b0, "div_13by4");  checkOutput(4);
        applyStimulus(OP_DIV, 4'd7,  4'd0,  1'b0, "div_7by0");   checkOutput(4);
        applyStimulus(OP_MUL, 4'd0,  4'd9,  1'b0, "mul_0x9");    checkOutput(4);
        applyStimulus(OP_MUL, 4'd12, 4'd11, 1'b0, "mul_12x11");  checkOutput(4);
        applyStimulus(OP_DIV, 4'd15, 4'd1,  1'b0, "div_15by1");  checkOutput(4);
        applyStimulus(OP_DIV, 4'd2,  4'd9,  1'b0, "div_2by9");   checkOutput(4);
        applyStimulus(OP_DIV, 4'd15, 4'd15, 1'b0, "div_15by15"); checkOutput(4);

        // Inputs and start toggled mid-RUN must not disturb the running multiply
        applyStimulus(OP_MUL, 4'd6, 4'd7, 1'b0, "mul_midrun");
        op    = OP_DIV;
        a     = 4'd1;
        b     = 4'd1;
        start = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        checkOutput(2);

        // Start held high: every DONE cycle re-accepts the same 3x5 multiply
        op    = OP_MUL;
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_t e;
            e.res = 8'h0F;
            e.dbz = 1'b0;
            e.tag = $sformatf("b2b_%0d", i);
            sbQ.push_back(e);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) checkOutput(4);
        check("b2b_reaccept_busy", busy, 1);
        start = 1'b0;

        // Asynchronous reset two steps into the re-accepted operation
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_dbz", divByZero, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        doneCount = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (done) doneCount++;
        end
        check("rst_no_done", doneCount, 0);
        check("rst_idle_busy", busy, 0);

`ifdef MULDIV4_SIGNED_EN
        applyStimulus(OP_MUL, 4'h9, 4'd3,  1'b1, "smul_m7x3");    checkOutput(4);
        applyStimulus(OP_DIV, 4'h8, 4'hF,  1'b1, "sdiv_m8bym1");  checkOutput(4);
        applyStimulus(OP_DIV, 4'd7, 4'hE,  1'b1, "sdiv_7bym2");   checkOutput(4);
        applyStimulus(OP_DIV, 4'hB, 4'd0,  1'b1, "sdiv_m5by0");   checkOutput(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule

// File: doc/muldiv4_seq_unit.md
Name: muldiv4_seq_unit

Overview:
- Iterative 4-bit unsigned multiplier/divider core with a start/busy/done handshake.
- Sits directly upstream of the result-flag combine logic (the OR-gate stage that merges done and error flags into the status byte).
- One algorithm step per clock: shift-add for multiply, restoring subtract for divide.
- Operands are latched at start; the result is held stable until the next start.

Parameters:
- WIDTH, 4, operand width in bits; result is 2*WIDTH bits.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when accepting (IDLE or DONE)
- op  in  1  0 = multiply, 1 = divide
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while in RUN
- done  out  1  single-cycle pulse when result is valid
- result  out  2*WIDTH  mul: product; div: {remainder, quotient}
- div_by_zero  out  1  high with result when op=1 and b=0; held with result

Behaviour:
- Interface (already decided): one clock, named clock; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE; busy=0, done=0, result=0, div_by_zero=0; counter and internal registers = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN; latch a, b, op; clear accumulator; counter=0.
  - RUN: one step per edge. After WIDTH steps → DONE, load result and div_by_zero.
  - DONE: done=1 for exactly one cycle. start=1 here → RUN (back-to-back, same latching as IDLE); else → IDLE.
- Latency: start sampled at edge k. Steps occur at edges k+1..k+WIDTH. done is high for the cycle after edge k+WIDTH. For WIDTH=4, done rises 4 edges after acceptance.
- Multiply: acc is 2*WIDTH bits. Each step, if multiplier LSB=1, add multiplicand to acc upper half (carry kept); then shift right. Product = a*b, no overflow possible.
- Divide (restoring): remainder register is WIDTH+1 bits. Each step:
  - shift in the next dividend MSB;
  - trial-subtract b;
  - if non-negative, keep the difference and set quotient bit=1; else restore and set quotient bit=0.
- b=0 needs no special path: quotient = all ones, remainder = a. div_by_zero=1, same latency.
- start while busy: ignored; operands are not re-latched. a, b and op may change freely during RUN.
- result and div_by_zero change only on the edge entering DONE (or on reset); they stay stable through IDLE.
- Reset mid-RUN: immediate return to reset values; no done pulse; the partial result is discarded.
- op is ignored outside acceptance.

Optional Feature:
- Macro: MULDIV4_SIGNED_EN.
- Defined: adds input signed_op (1 bit, sampled with start).
  - When signed_op=1, a and b are two's complement. Magnitudes are taken at latch, the unsigned core runs unchanged, and signs are applied on the DONE load.
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow: -2^(WIDTH-1) / -1 yields quotient 0x8 (wraps, for WIDTH=4), remainder 0.
  - Signed b=0: quotient forced to all ones, remainder = a, div_by_zero=1.
  - Latency is unchanged.
- Undefined: no signed_op port; behaviour is unsigned only.

Decomposition:
- Shared package muldiv4_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - OP_MUL=1'b0, OP_DIV=1'b1;
  - default WIDTH.
- One natural sub-module, muldiv4_addsub: a WIDTH+1-bit add/subtract with carry/borrow out. It is shared by the multiply add step and the divide trial subtract, selected by op.
- The FSM, counter and datapath registers stay in the top module.

Test Plan:
- Multiply max: op=0, a=15, b=15, start pulse → done high exactly 4 edges after acceptance; result=0xE1, div_by_zero=0.
- Divide: op=1, a=13, b=4 → result=0x13 (remainder 1, quotient 3), div_by_zero=0.
- Divide by zero: op=1, a=7, b=0 → result=0x7F, div_by_zero=1, same 4-cycle latency.
- Handshake:
  - start held high continuously with a=3, b=5, op=0 → every done pulse gives 0x0F, with back-to-back acceptance from DONE;
  - new a, b driven mid-RUN → ignored.
- Reset mid-RUN: assert reset asynchronously at step 2 → busy, done and result go to 0 immediately, without waiting for a clock edge; no done pulse follows.
- With MULDIV4_SIGNED_EN defined:
  - signed_op=1, a=-7 (0x9), b=3, op=0 → result=0xEB (-21);
  - op=1, a=-8, b=-1 → result=0x08 (quotient 0x8, remainder 0).
